left_to_right: RTL and testbench

LEFT_TO_RIGHT -- requirements
Module: left_to_right

---
 rtl/left_to_right_pkg.sv | 13 +
 rtl/left_to_right_step_prescaler.sv | 30 +++
 rtl/left_to_right.sv | 88 ++++++++
 tb/tb_left_to_right.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/left_to_right_pkg.sv
// Shared constants and types for the left_to_right LED chaser.
// LED_INIT is the reset/recovery pattern; dir_e is used only when bounce motion is built in.
package left_to_right_pkg;
  localparam int LED_W = 8;
  localparam logic [LED_W-1:0] LED_INIT  = 8'h80;
  localparam logic [LED_W-1:0] LED_RIGHT = 8'h01;

  typedef enum logic {DIR_RIGHT, DIR_LEFT} dir_e;

  function automatic logic is_onehot(input logic [LED_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction
endpackage

// File: rtl/left_to_right_step_prescaler.sv
// Step prescaler: counts 0..DIV-1 and strobes step while the count sits at DIV-1.
// Step is combinational from the count register; synchronous active-low reset clears the count.
module step_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic step
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 1) begin : g_bad_div
    $error("step_prescaler: DIV must be at least 1");
  end

  logic [CW-1:0] cnt;

  assign step = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/left_to_right.sv
// One-hot LED chaser moving right one position every STEP_DIV cycles, wrapping 01 -> 80.
// Define LEFT_TO_RIGHT_BOUNCE_EN for ping-pong motion instead of wrapping.
module left_to_right
  import left_to_right_pkg::*;
#(
  parameter int STEP_DIV = 4
) (
  input  logic             clk,
  input  logic             reset,
  output logic [LED_W-1:0] LED8
);
  if (STEP_DIV < 1) begin : g_bad_step_div
    $error("left_to_right: STEP_DIV must be at least 1");
  end

  logic             step;
  logic [LED_W-1:0] led_nxt;

  step_prescaler #(
    .DIV(STEP_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .step (step)
  );

`ifdef LEFT_TO_RIGHT_BOUNCE_EN
  dir_e dir;
  dir_e dir_nxt;

  // A corrupted (non-one-hot or X) pattern falls to the else branch and recovers to LED_INIT.
  always_comb begin
    led_nxt = LED8;
    dir_nxt = dir;
    if (step) begin
      if (is_onehot(LED8)) begin
        if (dir == DIR_RIGHT) begin
          if (LED8 == LED_RIGHT) begin
            led_nxt = LED_RIGHT << 1;
            dir_nxt = DIR_LEFT;
          end else begin
            led_nxt = LED8 >> 1;
          end
        end else begin
          if (LED8 == LED_INIT) begin
            led_nxt = LED_INIT >> 1;
            dir_nxt = DIR_RIGHT;
          end else begin
            led_nxt = LED8 << 1;
          end
        end
      end else begin
        led_nxt = LED_INIT;
        dir_nxt = DIR_RIGHT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      LED8 <= LED_INIT;
      dir  <= DIR_RIGHT;
    end else begin
      LED8 <= led_nxt;
      dir  <= dir_nxt;
    end
  end
`else
  always_comb begin
    led_nxt = LED8;
    if (step) begin
      if (is_onehot(LED8)) begin
        led_nxt = {LED8[0], LED8[LED_W-1:1]};
      end else begin
        led_nxt = LED_INIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      LED8 <= LED_INIT;
    end else begin
      LED8 <= led_nxt;
    end
  end
`endif
endmodule

// File: tb/tb_left_to_right.sv
// Bench for left_to_right: STEP_DIV=1 and STEP_DIV=4 instances on a shared clock.
// Follows LEFT_TO_RIGHT_BOUNCE_EN to pick wrap or ping-pong expectations.
module tb_left_to_right;
  typedef struct {
    logic       rst;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       r1  = 1'b0;
  logic       r4  = 1'b0;
  logic [7:0] l1;
  logic [7:0] l4;

  int total = 0;
  int bad   = 0;

  logic [7:0] q1[$];
  logic [7:0] q4[$];
  vec_t       vecs1[$];
  vec_t       vecs4[$];

  logic [7:0] m_led;
  logic       m_dir;

  always #5 clk = ~clk;

  left_to_right #(.STEP_DIV(1)) dut1 (.clk(clk), .reset(r1), .LED8(l1));
  left_to_right #(.STEP_DIV(4)) dut4 (.clk(clk), .reset(r4), .LED8(l4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run1(input logic rv, input logic [7:0] exp, input string nm);
    r1 = rv;
    q1.push_back(exp);
    tick();
    check(nm, {24'h0, l1}, {24'h0, q1.pop_front()});
  endtask

  task automatic run4(input logic rv, input logic [7:0] exp, input string nm);
    r4 = rv;
    q4.push_back(exp);
    tick();
    check(nm, {24'h0, l4}, {24'h0, q4.pop_front()});
  endtask

  task automatic model_next(input logic rv);
    if (!rv) begin
      m_led = 8'h80;
      m_dir = 1'b0;
    end else begin
`ifdef LEFT_TO_RIGHT_BOUNCE_EN
      if (!m_dir) begin
        if (m_led == 8'h01) begin
          m_led = 8'h02;
          m_dir = 1'b1;
        end else begin
          m_led = m_led >> 1;
        end
      end else begin
        if (m_led == 8'h80) begin
          m_led = 8'h40;
          m_dir = 1'b0;
        end else begin
          m_led = m_led << 1;
        end
      end
`else
      m_led = {m_led[0], m_led[7:1]};
`endif
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] run_exp[16];
    logic [7:0] seq4[18];
    logic       rst4[18];
    logic       rv;

`ifdef LEFT_TO_RIGHT_BOUNCE_EN
    run_exp = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02,
                8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20};
`else
    run_exp = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80,
                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
`endif
    // STEP_DIV=4: steps on edges 4, 8, 12; one-edge reset at edge 14 restarts the period.
    seq4 = '{8'h80, 8'h80, 8'h80, 8'h40, 8'h40, 8'h40, 8'h40, 8'h20, 8'h20,
             8'h20, 8'h20, 8'h10, 8'h10, 8'h80, 8'h80, 8'h80, 8'h80, 8'h40};
    rst4 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
             1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    vecs1.push_back('{1'b0, 8'h80});
    vecs1.push_back('{1'b0, 8'h80});
    for (int i = 0; i < 16; i++) vecs1.push_back('{1'b1, run_exp[i]});
    vecs1.push_back('{1'b0, 8'h80});
    vecs1.push_back('{1'b1, 8'h40});
    for (int i = 0; i < 18; i++) vecs4.push_back('{rst4[i], seq4[i]});

    // First reset edge: both instances at LED_INIT with the prescaler cleared.
    r1 = 1'b0;
    r4 = 1'b0;
    tick();
    check("rst_led1", {24'h0, l1}, 32'h80);
    check("rst_led4", {24'h0, l4}, 32'h80);
    check("rst_cnt1", 32'(dut1.u_prescaler.cnt), 32'h0);
    check("rst_cnt4", 32'(dut4.u_prescaler.cnt), 32'h0);

    foreach (vecs1[i]) run1(vecs1[i].rst, vecs1[i].exp, $sformatf("div1_vec%0d", i));
    check("rst_hold_cnt4", 32'(dut4.u_prescaler.cnt), 32'h0);
    foreach (vecs4[i]) run4(vecs4[i].rst, vecs4[i].exp, $sformatf("div4_vec%0d", i));

    r4 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      rv = (i == 0) ? 1'b0 : ($urandom_range(0, 7) != 0);
      model_next(rv);
      run1(rv, m_led, rv ? "rand_step" : "rand_reset");
      check("rand_onehot", {31'h0, $onehot(l1)}, 32'h1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
